// File: rtl/instruction_queue_if.sv
// Fetch/issue handshake bundle for the instruction queue.
// The queue takes the slave modport; the fetch/issue side takes master.
interface instruction_queue_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              flush;
  logic              if_we;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              iq_re;
  logic              iq_full;
  logic              iq_almost_full;
  logic              iq_empty;
  logic [31:0]       iq_inst;
  logic [31:0]       iq_pc;
  logic [ADDR_W:0]   iq_count;

  modport master (
    output flush, if_we, if_inst, if_pc, iq_re,
    input  iq_full, iq_almost_full, iq_empty, iq_inst, iq_pc, iq_count
  );

  modport slave (
    input  flush, if_we, if_inst, if_pc, iq_re,
    output iq_full, iq_almost_full, iq_empty, iq_inst, iq_pc, iq_count
  );
endinterface

// File: rtl/instruction_queue.sv
// In-order first-word-fall-through FIFO between fetch and issue.
// Flags and head outputs depend only on registered state; flush empties it in one edge.
module instruction_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 14
) (
  input logic                  clk,
  input logic                  rst,
  instruction_queue_if.slave   iq
);

  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AfCnt    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic full, empty;
  logic wr_en, rd_en;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // A full queue drops the write even if a read frees a slot this cycle.
  assign wr_en = iq.if_we && !full && !iq.flush;
  assign rd_en = iq.iq_re && !empty && !iq.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PtrOne;
      if (rd_en) head_d = head_q + PtrOne;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      inst_mem[tail_q] <= iq.if_inst;
      pc_mem[tail_q]   <= iq.if_pc;
    end
  end

  always_comb begin
    iq.iq_full        = full;
    iq.iq_almost_full = (count_q >= AfCnt);
    iq.iq_empty       = empty;
    iq.iq_count       = count_q;
    iq.iq_inst        = empty ? 32'h0 : inst_mem[head_q];
    iq.iq_pc          = empty ? 32'h0 : pc_mem[head_q];
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed scenarios plus random traffic against a queue model.
module tb_instruction_queue;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] mq[$];  // model entries as {pc, inst}, front is the head

  instruction_queue_if #(.ADDR_W(4)) bus ();

  instruction_queue #(
    .DEPTH   (16),
    .ADDR_W  (4),
    .AF_LEVEL(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iq (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given inputs; model follows the accept rules.
  task automatic drive(input logic we, input logic [31:0] inst, input logic [31:0] pc,
                       input logic re, input logic fl);
    bit was_full, was_empty;
    bus.if_we   = we;
    bus.if_inst = inst;
    bus.if_pc   = pc;
    bus.iq_re   = re;
    bus.flush   = fl;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (re && !was_empty) void'(mq.pop_front());
      if (we && !was_full) mq.push_back({pc, inst});
    end
    #1;
    bus.if_we = 1'b0;
    bus.iq_re = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (bus.iq_empty !== 1'b1 || bus.iq_count !== 5'd0 || bus.iq_inst !== 32'h0 ||
        bus.iq_pc !== 32'h0 || bus.iq_full !== 1'b0 || bus.iq_almost_full !== 1'b0) begin
      bad++;
      $display("FAIL reset: empty=%b count=%0d inst=%h pc=%h full=%b af=%b, want 1 0 0 0 0 0",
               bus.iq_empty, bus.iq_count, bus.iq_inst, bus.iq_pc, bus.iq_full,
               bus.iq_almost_full);
    end
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    pcs   = '{32'h0, 32'h4, 32'h8};
    insts = '{32'h00000013, 32'h00100093, 32'h00200113};
    drive(1'b1, insts[0], pcs[0], 1'b0, 1'b0);
    total++;
    if (bus.iq_empty !== 1'b0 || bus.iq_pc !== 32'h0 || bus.iq_inst !== 32'h00000013) begin
      bad++;
      $display("FAIL basic_latency: empty=%b pc=%h inst=%h, want 0 0 00000013",
               bus.iq_empty, bus.iq_pc, bus.iq_inst);
    end
    for (int i = 1; i < 3; i++) drive(1'b1, insts[i], pcs[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.iq_pc !== pcs[i] || bus.iq_inst !== insts[i]) begin
        bad++;
        $display("FAIL basic_order[%0d]: pc=%h inst=%h, want %h %h", i, bus.iq_pc,
                 bus.iq_inst, pcs[i], insts[i]);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    total++;
    if (bus.iq_empty !== 1'b1 || bus.iq_count !== 5'd0 || bus.iq_pc !== 32'h0) begin
      bad++;
      $display("FAIL basic_empty: empty=%b count=%0d pc=%h, want 1 0 0", bus.iq_empty,
               bus.iq_count, bus.iq_pc);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 32'(4 * i), 1'b0, 1'b0);
      total++;
      if (bus.iq_almost_full !== ((i + 1) >= 14) || bus.iq_full !== ((i + 1) == 16) ||
          bus.iq_count !== 5'(i + 1)) begin
        bad++;
        $display("FAIL fill[%0d]: af=%b full=%b count=%0d, want %b %b %0d", i,
                 bus.iq_almost_full, bus.iq_full, bus.iq_count, (i + 1) >= 14,
                 (i + 1) == 16, i + 1);
      end
    end
    drive(1'b1, 32'hBAD, 32'h40, 1'b0, 1'b0);
    total++;
    if (bus.iq_count !== 5'd16 || bus.iq_pc !== 32'h0) begin
      bad++;
      $display("FAIL overflow_drop: count=%0d head_pc=%h, want 16 0", bus.iq_count, bus.iq_pc);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.iq_pc !== 32'(4 * i) || bus.iq_inst !== 32'hA000_0000 + i) begin
        bad++;
        $display("FAIL drain[%0d]: pc=%h inst=%h, want %h %h", i, bus.iq_pc, bus.iq_inst,
                 4 * i, 32'hA000_0000 + i);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    total++;
    if (bus.iq_empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: empty=%b, want 1", bus.iq_empty);
    end
  endtask

  task automatic test_wrap();
    int wr_k, rd_k;
    wr_k = 0;
    rd_k = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(wr_k), 32'h1000 + 32'(4 * wr_k), 1'b0, 1'b0);
      wr_k++;
    end
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 32'(wr_k), 32'h1000 + 32'(4 * wr_k), 1'b1, 1'b0);
      wr_k++;
      rd_k++;
      total++;
      if (bus.iq_count !== 5'd5 || bus.iq_pc !== 32'h1000 + 32'(4 * rd_k)) begin
        bad++;
        $display("FAIL wrap[%0d]: count=%0d pc=%h, want 5 %h", c, bus.iq_count, bus.iq_pc,
                 32'h1000 + 32'(4 * rd_k));
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h55 + i, 32'h2000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'h77, 32'h3000, 1'b1, 1'b1);
    total++;
    if (bus.iq_empty !== 1'b1 || bus.iq_count !== 5'd0) begin
      bad++;
      $display("FAIL flush: empty=%b count=%0d, want 1 0", bus.iq_empty, bus.iq_count);
    end
    drive(1'b1, 32'h13, 32'h100, 1'b0, 1'b0);
    total++;
    if (bus.iq_empty !== 1'b0 || bus.iq_pc !== 32'h100 || bus.iq_count !== 5'd1) begin
      bad++;
      $display("FAIL flush_refill: empty=%b pc=%h count=%0d, want 0 100 1", bus.iq_empty,
               bus.iq_pc, bus.iq_count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_empty_read_full_write();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total++;
    if (bus.iq_count !== 5'd0 || bus.iq_empty !== 1'b1) begin
      bad++;
      $display("FAIL empty_read: count=%0d empty=%b, want 0 1", bus.iq_count, bus.iq_empty);
    end
    for (int i = 0; i < 16; i++) drive(1'b1, 32'hC0 + i, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD, 32'hDEAD0, 1'b1, 1'b0);
    total++;
    if (bus.iq_count !== 5'd15 || bus.iq_pc !== 32'h204) begin
      bad++;
      $display("FAIL full_rw: count=%0d pc=%h, want 15 204", bus.iq_count, bus.iq_pc);
    end
    for (int i = 1; i < 16; i++) begin
      total++;
      if (bus.iq_pc !== 32'h200 + 32'(4 * i)) begin
        bad++;
        $display("FAIL full_rw_drain[%0d]: pc=%h, want %h", i, bus.iq_pc,
                 32'h200 + 32'(4 * i));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    total++;
    if (bus.iq_empty !== 1'b1) begin
      bad++;
      $display("FAIL full_rw_dropped: empty=%b pc=%h, want 1 0", bus.iq_empty, bus.iq_pc);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h900 + i, 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.iq_empty !== 1'b1 || bus.iq_count !== 5'd0 || bus.iq_pc !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: empty=%b count=%0d pc=%h, want 1 0 0", bus.iq_empty,
               bus.iq_count, bus.iq_pc);
    end
    #1;
    rst = 1'b0;
    mq.delete();
    drive(1'b1, 32'h1, 32'h500, 1'b0, 1'b0);
    total++;
    if (bus.iq_count !== 5'd1 || bus.iq_pc !== 32'h500) begin
      bad++;
      $display("FAIL async_resume: count=%0d pc=%h, want 1 500", bus.iq_count, bus.iq_pc);
    end
  endtask

  task automatic test_random();
    logic [63:0] h;
    logic [4:0]  ecount;
    int          nerr;
    nerr = 0;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 60), $urandom, $urandom, ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 63) == 0));
      h      = (mq.size() != 0) ? mq[0] : 64'h0;
      ecount = 5'(mq.size());
      total++;
      if (bus.iq_count !== ecount || bus.iq_empty !== (mq.size() == 0) ||
          bus.iq_full !== (mq.size() == 16) || bus.iq_almost_full !== (mq.size() >= 14) ||
          bus.iq_pc !== h[63:32] || bus.iq_inst !== h[31:0]) begin
        bad++;
        if (nerr < 10)
          $display("FAIL random[%0d]: count=%0d pc=%h inst=%h, want %0d %h %h", c,
                   bus.iq_count, bus.iq_pc, bus.iq_inst, ecount, h[63:32], h[31:0]);
        nerr++;
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    bus.flush   = 1'b0;
    bus.if_we   = 1'b0;
    bus.if_inst = 32'h0;
    bus.if_pc   = 32'h0;
    bus.iq_re   = 1'b0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_wrap();
    test_flush();
    test_empty_read_full_write();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

In-order FIFO between the fetch stage and `issue_unit`. It buffers fetched instruction words with their PCs and presents the oldest entry to issue in first-word-fall-through form. `flush` from branch misprediction recovery empties it in one cycle. It is the producer end of the `iq_empty` / `iq_inst` / `iq_pc` / `iq_re` interface that `issue_unit` consumes.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `ADDR_W`, 4: log2(`DEPTH`).
- `AF_LEVEL`, 14: `iq_almost_full` asserts when count ≥ this value.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  discard all entries (misprediction / ROB recovery).
- `if_we`  in  1  fetch presents a valid instruction this cycle.
- `if_inst`  in  32  fetched instruction word.
- `if_pc`  in  32  PC of `if_inst`.
- `iq_full`  out  1  count == `DEPTH`.
- `iq_almost_full`  out  1  count ≥ `AF_LEVEL`; fetch uses it to throttle in-flight requests.
- `iq_empty`  out  1  count == 0.
- `iq_inst`  out  32  head instruction; `32'h0` when empty.
- `iq_pc`  out  32  head PC; `32'h0` when empty.
- `iq_re`  in  1  issue consumes the head entry this cycle.
- `iq_count`  out  `ADDR_W+1`  number of valid entries.

## Operation
- State:
  - storage arrays `inst_mem[DEPTH]` and `pc_mem[DEPTH]`;
  - `head` and `tail`, both `ADDR_W` bits;
  - `count`, `ADDR_W+1` bits.
- Accept conditions:
  - write is accepted iff `if_we && !iq_full && !flush`;
  - read is accepted iff `iq_re && !iq_empty && !flush`.
- Full and empty flags come from the registered `count`.
  - A write when full is dropped, even if a read occurs in the same cycle. Fetch must hold and retry.
  - `iq_re` when empty is ignored and nothing changes.
- Accepted write: store at `tail`, then `tail <= tail + 1`.
- Accepted read: `head <= head + 1`.
- Pointers wrap modulo `DEPTH` by natural `ADDR_W`-bit overflow.
- Count update:
  - write only: +1;
  - read only: −1;
  - both: unchanged;
  - neither: unchanged.
- `flush`:
  - next edge sets `head <= 0`, `tail <= 0`, `count <= 0`;
  - a write or read in the same cycle is discarded;
  - storage contents are not cleared.
- Head outputs:
  - `iq_inst = iq_empty ? 0 : inst_mem[head]`, and `iq_pc` likewise from `pc_mem[head]`;
  - both are combinational from registered state only;
  - no combinational path from `if_*` or `iq_re` to any output.
- `rst` asynchronously clears `head`, `tail` and `count`. Storage is not reset.
- Simulation-only `$display` trace on each accepted write and read is permitted.

## Timing
- Reset values:
  - `iq_empty = 1`, `iq_full = 0`, `iq_almost_full = 0`;
  - `iq_count = 0`, `iq_inst = 0`, `iq_pc = 0`.
- Write-to-visible latency is 1 cycle: a write accepted at edge N makes the entry visible at the head, with `iq_empty` = 0, after edge N. There is no same-cycle bypass.
- Read: the head advances at the consuming edge. The next entry, or empty, is presented in the following cycle.
- Simultaneous read and write when count == 1: after the edge, count == 1 and the head is the newly written entry.
- Flags update one edge after the causing event.
- Asserting `rst` mid-operation clears the queue immediately, without waiting for a clock edge. Operation resumes on the first edge after deassertion.

## Test plan
- **Reset and basic FIFO:**
  - assert `rst`; check `iq_empty` = 1, `iq_count` = 0, `iq_inst` = 0;
  - write PCs `0x00`, `0x04`, `0x08` with `inst` = `0x00000013`, `0x00100093`, `0x00200113`;
  - read 3 times; check the same order and values, then `iq_empty` = 1.
- **Fill and overflow:**
  - write 16 entries (`pc = 4*i`); check `iq_almost_full` rises at count 14 and `iq_full` at 16;
  - a 17th write with `if_pc = 0x40` is dropped;
  - drain all 16; check PCs `0x00`–`0x3C` in order.
- **Wrap-around:**
  - loop 40 cycles with concurrent write and read at count 5;
  - check the count stays 5 and PCs are strictly sequential across pointer wrap.
- **Flush:**
  - with 8 entries, assert `flush` together with `if_we` and `iq_re`;
  - next cycle check `iq_empty` = 1 and count = 0;
  - a following write of `pc = 0x100` appears at the head after one edge.
- **Read when empty / write when full with read:**
  - `iq_re` on an empty queue leaves count at 0;
  - at count 16, asserting `if_we` and `iq_re` together gives count 15 and the write is not stored.
- **Async reset mid-stream:**
  - pulse `rst` between edges with 6 entries;
  - check `iq_empty` = 1 immediately, before the next edge.
